// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_port_arbiter
// Description : Two-requester ownership arbiter in front of a single DDR
//               master port. Option macro: DDR_ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_acquire,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  input  logic [BURST_W-1:0]  p0_burstcnt,
  output logic                p0_busy,
  output logic [DATA_W-1:0]   p0_rdata,
  output logic                p0_rdata_ready,
  input  logic                p1_acquire,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  input  logic [BURST_W-1:0]  p1_burstcnt,
  output logic                p1_busy,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic                p1_rdata_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [BURST_W-1:0]  mem_burstcnt,
  input  logic                mem_busy,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdata_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [BURST_W:0]   PEND_ONE = {{BURST_W{1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] WR_ONE   = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic [BURST_W:0]   rd_pend;
  logic [BURST_W-1:0] wr_left;
  logic               err_flag;
  logic               p0_req;
  logic               p1_req;
  logic               owner_req;
  logic               prio0;
  logic               rd_acc;
  logic               wr_acc;
  logic               beat;

  assign p0_req   = p0_acquire | p0_read | p0_write;
  assign p1_req   = p1_acquire | p1_read | p1_write;
  assign rd_acc   = mem_read & ~mem_busy;
  assign wr_acc   = mem_write & ~mem_busy;
  // Beats arriving with nothing outstanding are not handed to anyone.
  assign beat     = mem_rdata_ready & (state != IDLE) & (rd_pend != '0);
  assign p0_rdata = mem_rdata;
  assign p1_rdata = mem_rdata;

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic last_grant;

  assign prio0 = last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_grant <= (state_nxt == OWN1);
    end
  end
`else
  assign prio0 = 1'b1;
`endif

  always_comb begin
    state_nxt      = state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_byteenable = '1;
    mem_burstcnt   = '0;
    p0_busy        = 1'b1;
    p1_busy        = 1'b1;
    p0_rdata_ready = 1'b0;
    p1_rdata_ready = 1'b0;
    owner_req      = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req && (!p1_req || prio0)) begin
          state_nxt = OWN0;
        end else if (p1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        mem_read       = p0_read;
        mem_write      = p0_write;
        mem_addr       = p0_addr;
        mem_wdata      = p0_wdata;
        mem_byteenable = p0_byteenable;
        mem_burstcnt   = p0_burstcnt;
        p0_busy        = mem_busy;
        p0_rdata_ready = beat;
        owner_req      = p0_req;
      end
      OWN1: begin
        mem_read       = p1_read;
        mem_write      = p1_write;
        mem_addr       = p1_addr;
        mem_wdata      = p1_wdata;
        mem_byteenable = p1_byteenable;
        mem_burstcnt   = p1_burstcnt;
        p1_busy        = mem_busy;
        p1_rdata_ready = beat;
        owner_req      = p1_req;
      end
      default: state_nxt = IDLE;
    endcase
    // Ownership is held until the owner lets go and every burst has drained.
    if (state != IDLE && !owner_req && rd_pend == '0 && wr_left == '0) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_pend  <= '0;
      wr_left  <= '0;
      err_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      case ({rd_acc, beat})
        2'b10:   rd_pend <= rd_pend + {1'b0, mem_burstcnt};
        2'b11:   rd_pend <= rd_pend + {1'b0, mem_burstcnt} - PEND_ONE;
        2'b01:   rd_pend <= rd_pend - PEND_ONE;
        default: rd_pend <= rd_pend;
      endcase
      if (wr_acc) begin
        wr_left <= (wr_left == '0) ? (mem_burstcnt - WR_ONE) : (wr_left - WR_ONE);
      end
      if (mem_rdata_ready && !beat) begin
        err_flag <= 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !err_flag);

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_port_arbiter
// Description : Randomized requester/memory traffic against an ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;
  localparam int BE_W    = DATA_W / 8;
  localparam int NCYC    = 6000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              acq [2];
  logic              rd  [2];
  logic              wr  [2];
  logic [ADDR_W-1:0] addr[2];
  logic [DATA_W-1:0] wdat[2];
  logic [BE_W-1:0]   be  [2];
  logic [BURST_W-1:0] bc [2];
  logic              mem_busy;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_ready;

  logic              p0_busy, p1_busy, p0_rdata_ready, p1_rdata_ready;
  logic [DATA_W-1:0] p0_rdata, p1_rdata, mem_wdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_byteenable;
  logic [BURST_W-1:0] mem_burstcnt;

  ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset(reset),
    .p0_acquire(acq[0]), .p0_read(rd[0]), .p0_write(wr[0]), .p0_addr(addr[0]),
    .p0_wdata(wdat[0]), .p0_byteenable(be[0]), .p0_burstcnt(bc[0]),
    .p0_busy(p0_busy), .p0_rdata(p0_rdata), .p0_rdata_ready(p0_rdata_ready),
    .p1_acquire(acq[1]), .p1_read(rd[1]), .p1_write(wr[1]), .p1_addr(addr[1]),
    .p1_wdata(wdat[1]), .p1_byteenable(be[1]), .p1_burstcnt(bc[1]),
    .p1_busy(p1_busy), .p1_rdata(p1_rdata), .p1_rdata_ready(p1_rdata_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteenable(mem_byteenable), .mem_burstcnt(mem_burstcnt),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rdata_ready(mem_rdata_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: who owns the port, outstanding read beats, write beats left.
  int owner;
  int pend;
  int wleft;
  int last;
  // Requester behaviour: 0 idle, 1 reading, 2 writing, 3 holding acquire only.
  int ph[2];
  int left[2];
  int linger[2];
  bit noacq[2];
  bit exp_busy[2];

  function automatic bit req(input int n);
    return acq[n] | rd[n] | wr[n];
  endfunction

  task automatic model_reset();
    owner = -1; pend = 0; wleft = 0; last = 1;
    for (int n = 0; n < 2; n++) begin
      ph[n] = 0; left[n] = 0; linger[n] = 0; noacq[n] = 1'b0;
      acq[n] = 1'b0; rd[n] = 1'b0; wr[n] = 1'b0;
      addr[n] = '0; wdat[n] = '0; be[n] = '1; bc[n] = 8'd1;
    end
    mem_busy = 1'b0; mem_rdata_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic start_txn(input int n);
    int k;
    k = $urandom_range(0, 9);
    bc[n]    = BURST_W'($urandom_range(1, 4));
    addr[n]  = $urandom;
    wdat[n]  = {$urandom, $urandom};
    be[n]    = BE_W'($urandom);
    left[n]  = int'(bc[n]);
    linger[n] = $urandom_range(0, 3);
    noacq[n] = ($urandom_range(0, 3) == 0);
    ph[n]    = (k < 4) ? 1 : (k < 8) ? 2 : 3;
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < 2; n++) begin
      rd[n]  = (ph[n] == 1);
      wr[n]  = (ph[n] == 2);
      acq[n] = (ph[n] != 0) && !(noacq[n] && (ph[n] == 1 || ph[n] == 2));
    end
    mem_busy        = ($urandom_range(0, 2) == 0);
    mem_rdata_ready = (pend > 0) && ($urandom_range(0, 1) == 1);
    mem_rdata       = {$urandom, $urandom};
  endtask

  task automatic check_outputs();
    logic               e_rd, e_wr;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_wd;
    logic [BE_W-1:0]    e_be;
    logic [BURST_W-1:0] e_bc;
    bit                 e_rr[2];
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0; e_be = '1; e_bc = '0;
    for (int n = 0; n < 2; n++) begin
      exp_busy[n] = (owner != n) || mem_busy;
      e_rr[n]     = (owner == n) && mem_rdata_ready && (pend > 0);
      if (owner == n) begin
        e_rd = rd[n]; e_wr = wr[n]; e_addr = addr[n];
        e_wd = wdat[n]; e_be = be[n]; e_bc = bc[n];
      end
    end
    check("mem_read", mem_read, e_rd);
    check("mem_write", mem_write, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_burstcnt", mem_burstcnt, e_bc);
    check("mem_wdata", mem_wdata, e_wd);
    check("mem_byteenable", mem_byteenable, e_be);
    check("busy", {p0_busy, p1_busy}, {exp_busy[0], exp_busy[1]});
    check("rdata_ready", {p0_rdata_ready, p1_rdata_ready}, {e_rr[0], e_rr[1]});
    check("rdata_pass", p0_rdata ^ p1_rdata ^ mem_rdata, mem_rdata);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {p0_busy, p1_busy}, 2'b11);
    check({tag, "_rw"}, {mem_read, mem_write}, 2'b00);
    check({tag, "_rr"}, {p0_rdata_ready, p1_rdata_ready}, 2'b00);
    check({tag, "_addr"}, mem_addr, '0);
    check({tag, "_bc"}, mem_burstcnt, '0);
    check({tag, "_be"}, mem_byteenable, 8'hFF);
  endtask

  // Applied at the clock edge using values that were stable before it.
  task automatic step_model();
    int  nxt;
    int  n;
    bit  rel;
    bit  r0, r1;
    int  p_old;
    if (owner < 0) begin
      r0 = req(0); r1 = req(1);
      nxt = -1;
      if (r0 && r1) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
        nxt = (last == 1) ? 0 : 1;
`else
        nxt = 0;
`endif
      end else if (r0) nxt = 0;
      else if (r1) nxt = 1;
      if (nxt >= 0) last = nxt;
    end else begin
      n     = owner;
      p_old = pend;
      rel   = !req(n) && pend == 0 && wleft == 0;
      if (rd[n] && !mem_busy) pend += int'(bc[n]);
      if (mem_rdata_ready && p_old > 0) pend -= 1;
      if (wr[n] && !mem_busy) wleft = (wleft == 0) ? int'(bc[n]) - 1 : wleft - 1;
      nxt = rel ? -1 : n;
    end
    owner = nxt;
    for (int i = 0; i < 2; i++) begin
      case (ph[i])
        0: if ($urandom_range(0, 3) == 0) start_txn(i);
        1: if (!exp_busy[i]) ph[i] = 3;
        2: if (!exp_busy[i]) begin
             left[i]--;
             wdat[i] = {$urandom, $urandom};
             be[i]   = BE_W'($urandom);
             if (left[i] == 0) ph[i] = 3;
           end
        default: begin
          if ($urandom_range(0, 9) < 3) start_txn(i);
          else if (linger[i] == 0) ph[i] = 0;
          else linger[i]--;
        end
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Occasionally hit reset in the middle of live traffic.
      if (cyc % 701 == 350) begin
        drive_inputs();
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
      drive_inputs();
      #1;
      check_outputs();
      @(posedge clk);
      step_model();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
